// File: rtl/pa_idu_wb_port_ctrl_pkg.sv
// rtl/pa_idu_wb_port_ctrl_pkg.sv - shared encodings and widths for GPR write-back port control
package pa_idu_wb_port_ctrl_pkg;

  localparam int GPR_IDX_W      = 5;
  localparam int STARVE_MAX_DEF = 4;
  localparam int CNT_W          = 4;

  typedef enum logic {
    PRI_LSU   = 1'b0,
    FORCE_DIV = 1'b1
  } p1_state_e;

endpackage

// File: rtl/pa_idu_wb_rd_dec.sv
// rtl/pa_idu_wb_rd_dec.sv - one-hot destination decoder with x0 masked
module pa_idu_wb_rd_dec
  import pa_idu_wb_port_ctrl_pkg::*;
#(
  parameter int GPR_NUM = 32
) (
  input  logic                 vld,
  input  logic [GPR_IDX_W-1:0] rd,
  output logic [GPR_NUM-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (vld && (rd != '0)) begin
      onehot[rd] = 1'b1;
    end
  end

endmodule

// File: rtl/pa_idu_wb_port_ctrl.sv
// rtl/pa_idu_wb_port_ctrl.sv - GPR write-back sequencing: EX on port0, LSU/DIV arbitrated on port1
module pa_idu_wb_port_ctrl
  import pa_idu_wb_port_ctrl_pkg::*;
#(
  parameter int GPR_NUM    = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                 forever_cpuclk,
  input  logic                 cpurst_b,
  input  logic                 ex_wb_vld,
  input  logic [GPR_IDX_W-1:0] ex_wb_rd,
  input  logic [31:0]          ex_wb_data,
  input  logic                 lsu_wb_vld,
  input  logic [GPR_IDX_W-1:0] lsu_wb_rd,
  input  logic [31:0]          lsu_wb_data,
  output logic                 lsu_wb_stall,
  input  logic                 div_wb_vld,
  input  logic [GPR_IDX_W-1:0] div_wb_rd,
  input  logic [31:0]          div_wb_data,
  output logic                 div_wb_grnt,
  output logic [GPR_NUM-1:0]   wb_write_en0,
  output logic [GPR_NUM-1:0]   wb_write_en1,
  output logic [GPR_NUM-1:0]   wb_fwd_en0,
  output logic [GPR_NUM-1:0]   wb_fwd_en1,
  output logic [31:0]          wb_write_data0,
  output logic [31:0]          wb_write_data1,
  output logic                 wb_port1_is_div
);

  localparam logic [CNT_W-1:0] STARVE_M1 = CNT_W'(STARVE_MAX - 1);

  p1_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [GPR_NUM-1:0]   en0_q, en0_d, en1_q, en1_d;
  logic [31:0]          data0_q, data0_d, data1_q, data1_d;
  logic                 is_div_q, is_div_d;

  logic                 lsu_acc, div_acc, p1_vld, waw;
  logic [GPR_IDX_W-1:0] p1_rd;
  logic [31:0]          p1_data;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_wb_grnt  = 1'b0;
    lsu_wb_stall = 1'b0;
    lsu_acc      = 1'b0;
    case (state_q)
      PRI_LSU: begin
        lsu_acc     = lsu_wb_vld;
        div_wb_grnt = div_wb_vld & ~lsu_wb_vld;
        if (lsu_wb_vld && div_wb_vld) begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (cnt_q == STARVE_M1) begin
            state_d = FORCE_DIV;
          end
        end
        if (div_wb_grnt) begin
          cnt_d = '0;
        end
      end
      FORCE_DIV: begin
        div_wb_grnt  = 1'b1;
        lsu_wb_stall = lsu_wb_vld;
        state_d      = PRI_LSU;
        cnt_d        = '0;
      end
    endcase
  end

  // A forced grant only carries data when the divider actually presents a result.
  assign div_acc = div_wb_grnt & div_wb_vld;
  assign p1_vld  = lsu_acc | div_acc;
  assign p1_rd   = div_acc ? div_wb_rd : lsu_wb_rd;
  assign p1_data = div_acc ? div_wb_data : lsu_wb_data;

  // Same-cycle EX write to the same register is younger, so the port1 write is dropped.
  assign waw = ex_wb_vld & p1_vld & (ex_wb_rd == p1_rd) & (ex_wb_rd != '0);

  pa_idu_wb_rd_dec #(.GPR_NUM(GPR_NUM)) u_dec0 (
    .vld    (ex_wb_vld),
    .rd     (ex_wb_rd),
    .onehot (en0_d)
  );

  pa_idu_wb_rd_dec #(.GPR_NUM(GPR_NUM)) u_dec1 (
    .vld    (p1_vld & ~waw),
    .rd     (p1_rd),
    .onehot (en1_d)
  );

  always_comb begin
    data0_d  = ex_wb_vld ? ex_wb_data : data0_q;
    data1_d  = p1_vld ? p1_data : data1_q;
    is_div_d = div_acc;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q  <= PRI_LSU;
      cnt_q    <= '0;
      en0_q    <= '0;
      en1_q    <= '0;
      data0_q  <= '0;
      data1_q  <= '0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      en0_q    <= en0_d;
      en1_q    <= en1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      is_div_q <= is_div_d;
    end
  end

  assign wb_write_en0    = en0_q;
  assign wb_write_en1    = en1_q;
  assign wb_fwd_en0      = en0_q;
  assign wb_fwd_en1      = en1_q;
  assign wb_write_data0  = data0_q;
  assign wb_write_data1  = data1_q;
  assign wb_port1_is_div = is_div_q;

endmodule

// File: tb/tb_pa_idu_wb_port_ctrl.sv
// tb/tb_pa_idu_wb_port_ctrl.sv - scoreboard bench for the GPR write-back port controller
module tb_pa_idu_wb_port_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_vld, lsu_vld, div_vld;
  logic [4:0]  ex_rd, lsu_rd, div_rd;
  logic [31:0] ex_data, lsu_data, div_data;
  logic        lsu_stall, div_grnt, is_div;
  logic [31:0] en0, en1, fwd0, fwd1, d0, d1;

  always #5 clk = ~clk;

  pa_idu_wb_port_ctrl dut (
    .forever_cpuclk  (clk),
    .cpurst_b        (rst_n),
    .ex_wb_vld       (ex_vld),
    .ex_wb_rd        (ex_rd),
    .ex_wb_data      (ex_data),
    .lsu_wb_vld      (lsu_vld),
    .lsu_wb_rd       (lsu_rd),
    .lsu_wb_data     (lsu_data),
    .lsu_wb_stall    (lsu_stall),
    .div_wb_vld      (div_vld),
    .div_wb_rd       (div_rd),
    .div_wb_data     (div_data),
    .div_wb_grnt     (div_grnt),
    .wb_write_en0    (en0),
    .wb_write_en1    (en1),
    .wb_fwd_en0      (fwd0),
    .wb_fwd_en1      (fwd1),
    .wb_write_data0  (d0),
    .wb_write_data1  (d1),
    .wb_port1_is_div (is_div)
  );

  typedef struct {
    string       name;
    logic        g;
    logic        s;
    logic [31:0] en0;
    logic [31:0] en1;
    logic        dv;
    logic [31:0] d0;
    logic [31:0] d1;
  } exp_t;

  exp_t comb_q[$];
  exp_t pend_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (pend_q.size() > 0) begin
      mon_e = pend_q.pop_front();
      chk({mon_e.name, "_en0"},  en0,  mon_e.en0);
      chk({mon_e.name, "_fwd0"}, fwd0, mon_e.en0);
      chk({mon_e.name, "_en1"},  en1,  mon_e.en1);
      chk({mon_e.name, "_fwd1"}, fwd1, mon_e.en1);
      chk({mon_e.name, "_isdiv"}, {31'd0, is_div}, {31'd0, mon_e.dv});
      chk({mon_e.name, "_d0"},   d0,   mon_e.d0);
      chk({mon_e.name, "_d1"},   d1,   mon_e.d1);
    end
    if (comb_q.size() > 0) begin
      mon_e = comb_q.pop_front();
      chk({mon_e.name, "_grnt"},  {31'd0, div_grnt},  {31'd0, mon_e.g});
      chk({mon_e.name, "_stall"}, {31'd0, lsu_stall}, {31'd0, mon_e.s});
      pend_q.push_back(mon_e);
    end
  end

  task automatic cyc(input string nm,
                     input logic ev, input logic [4:0] erd, input logic [31:0] ed,
                     input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                     input logic dv, input logic [4:0] drd, input logic [31:0] dd,
                     input logic xg, input logic xs,
                     input logic [31:0] xen0, input logic [31:0] xen1, input logic xdv,
                     input logic [31:0] xd0, input logic [31:0] xd1);
    exp_t e;
    @(posedge clk);
    #1;
    ex_vld = ev;  ex_rd = erd;  ex_data = ed;
    lsu_vld = lv; lsu_rd = lrd; lsu_data = ld;
    div_vld = dv; div_rd = drd; div_data = dd;
    e.name = nm; e.g = xg; e.s = xs; e.en0 = xen0; e.en1 = xen1;
    e.dv = xdv; e.d0 = xd0; e.d1 = xd1;
    comb_q.push_back(e);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_en0"}, en0, 32'h0);
    chk({nm, "_en1"}, en1, 32'h0);
    chk({nm, "_fwd0"}, fwd0, 32'h0);
    chk({nm, "_fwd1"}, fwd1, 32'h0);
    chk({nm, "_d0"}, d0, 32'h0);
    chk({nm, "_d1"}, d1, 32'h0);
    chk({nm, "_isdiv"}, {31'd0, is_div}, 32'h0);
  endtask

  initial begin
    ex_vld = 0; ex_rd = 0; ex_data = 0;
    lsu_vld = 0; lsu_rd = 0; lsu_data = 0;
    div_vld = 0; div_rd = 0; div_data = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_grnt", {31'd0, div_grnt}, 32'h0);
    chk("reset_stall", {31'd0, lsu_stall}, 32'h0);
    rst_n = 1'b1;

    cyc("t1_ex", 1, 5, 32'h1234, 0, 0, 0, 0, 0, 0,
        0, 0, 32'h20, 32'h0, 0, 32'h1234, 32'h0);
    cyc("t2_lsu", 0, 0, 0, 1, 3, 32'hAAAA0003, 1, 7, 32'hDDDD0007,
        0, 0, 32'h0, 32'h8, 0, 32'h1234, 32'hAAAA0003);
    cyc("t2_div", 0, 0, 0, 0, 0, 0, 1, 7, 32'hDDDD0007,
        1, 0, 32'h0, 32'h80, 1, 32'h1234, 32'hDDDD0007);
    for (int i = 0; i < 4; i++) begin
      cyc("t3_lsu", 0, 0, 0, 1, 5'(10 + i), 32'h100 + i, 1, 20, 32'hD1D1D1D1,
          0, 0, 32'h0, 32'h1 << (10 + i), 0, 32'h1234, 32'h100 + i);
    end
    cyc("t3_force", 0, 0, 0, 1, 14, 32'h104, 1, 20, 32'hD1D1D1D1,
        1, 1, 32'h0, 32'h0010_0000, 1, 32'h1234, 32'hD1D1D1D1);
    cyc("t3_resume", 0, 0, 0, 1, 14, 32'h104, 0, 0, 0,
        0, 0, 32'h0, 32'h4000, 0, 32'h1234, 32'h104);
    cyc("t4_waw", 1, 9, 32'h9999, 1, 9, 32'h5555, 0, 0, 0,
        0, 0, 32'h200, 32'h0, 0, 32'h9999, 32'h5555);
    cyc("t5_x0", 1, 0, 32'h0E0E, 0, 0, 0, 1, 0, 32'h0D0D,
        1, 0, 32'h0, 32'h0, 1, 32'h0E0E, 32'h0D0D);
    cyc("t5_waw_div", 1, 31, 32'hAAAA0031, 0, 0, 0, 1, 31, 32'hBBBB0031,
        1, 0, 32'h8000_0000, 32'h0, 1, 32'hAAAA0031, 32'hBBBB0031);
    cyc("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 32'h0, 32'h0, 0, 32'hAAAA0031, 32'hBBBB0031);

    for (int i = 0; i < 4; i++) begin
      cyc("t6_pre", 0, 0, 0, 1, 5'(1 + i), 32'h201 + i, 1, 6, 32'h600,
          0, 0, 32'h0, 32'h1 << (1 + i), 0, 32'hAAAA0031, 32'h201 + i);
    end
    @(posedge clk);
    #1;
    lsu_vld = 1; lsu_rd = 5; lsu_data = 32'h205;
    div_vld = 1; div_rd = 6; div_data = 32'h600;
    #1;
    chk("t6_force_grnt", {31'd0, div_grnt}, 32'h1);
    chk("t6_force_stall", {31'd0, lsu_stall}, 32'h1);
    rst_n = 1'b0;
    comb_q.delete();
    pend_q.delete();
    #1;
    chk_all_zero("t6_rst");
    chk("t6_rst_grnt", {31'd0, div_grnt}, 32'h0);
    chk("t6_rst_stall", {31'd0, lsu_stall}, 32'h0);
    lsu_vld = 0; div_vld = 0;
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      cyc("t6_post", 0, 0, 0, 1, 5'(1 + i), 32'h301 + i, 1, 6, 32'h600,
          0, 0, 32'h0, 32'h1 << (1 + i), 0, 32'h0, 32'h301 + i);
    end
    cyc("t6_force2", 0, 0, 0, 1, 5, 32'h305, 1, 6, 32'h600,
        1, 1, 32'h0, 32'h40, 1, 32'h0, 32'h600);
    cyc("t6_resume", 0, 0, 0, 1, 5, 32'h305, 0, 0, 0,
        0, 0, 32'h0, 32'h20, 0, 32'h0, 32'h305);
    cyc("t6_idle", 0, 0, 0, 0, 0, 0, 0, 0, 0,
        0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h305);

    repeat (3) @(posedge clk);
    #1;
    chk("drain", comb_q.size() + pend_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
